// File: rtl/cdb_if.sv
// Source-side result queues and 4-lane CDB broadcast bus.
// The broadcaster uses the slave modport; producers and observers use master.
interface cdb_if #(
    parameter int NUM_SRC = 6,
    parameter int IDX_W   = 4,
    parameter int DATA_W  = 16
);
    logic [NUM_SRC-1:0]             src_valid;
    logic [NUM_SRC-1:0][IDX_W-1:0]  src_rob_index;
    logic [NUM_SRC-1:0][DATA_W-1:0] src_result;
    logic [NUM_SRC-1:0]             src_ready;
    logic [3:0]                     cdb_valid;
    logic [3:0][IDX_W-1:0]          cdb_rob_index;
    logic [3:0][DATA_W-1:0]         cdb_result;

    modport master (
        output src_valid, src_rob_index, src_result,
        input  src_ready, cdb_valid, cdb_rob_index, cdb_result
    );

    modport slave (
        input  src_valid, src_rob_index, src_result,
        output src_ready, cdb_valid, cdb_rob_index, cdb_result
    );
endinterface

// File: rtl/cdb_broadcaster.sv
// CDB transmitter: per-source result FIFOs, round-robin grant of up to four
// FIFO heads per cycle, and registered broadcast lanes.
module cdb_broadcaster #(
    parameter int NUM_SRC = 6,
    parameter int DEPTH   = 2,
    parameter int IDX_W   = 4,
    parameter int DATA_W  = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    cdb_if.slave  bus
);
    localparam int LANES = 4;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [IDX_W-1:0]  r_q_idx  [NUM_SRC][DEPTH];
    logic [DATA_W-1:0] r_q_data [NUM_SRC][DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr [NUM_SRC];
    logic [PTR_W-1:0]  r_rd_ptr [NUM_SRC];
    logic [CNT_W-1:0]  r_count  [NUM_SRC];
    logic [RR_W-1:0]   r_rr_ptr;

    logic [LANES-1:0]             r_cdb_valid;
    logic [LANES-1:0][IDX_W-1:0]  r_cdb_idx;
    logic [LANES-1:0][DATA_W-1:0] r_cdb_data;

    logic [NUM_SRC-1:0]           w_ready;
    logic [NUM_SRC-1:0]           w_push;
    logic [NUM_SRC-1:0]           w_grant;
    logic [LANES-1:0]             w_lane_valid;
    logic [LANES-1:0][IDX_W-1:0]  w_lane_idx;
    logic [LANES-1:0][DATA_W-1:0] w_lane_data;
    logic [RR_W-1:0]              w_rr_next;
    logic [RR_W:0]                w_scan;
    logic [RR_W-1:0]              w_src;
    logic [2:0]                   w_num;

    // Ready comes only from registered occupancy, never from same-cycle dequeue.
    always_comb begin
        w_ready = '0;
        w_push  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_ready[i] = (r_count[i] < CNT_W'(DEPTH));
            w_push[i]  = bus.src_valid[i] & w_ready[i];
        end
    end

    assign bus.src_ready     = w_ready;
    assign bus.cdb_valid     = r_cdb_valid;
    assign bus.cdb_rob_index = r_cdb_idx;
    assign bus.cdb_result    = r_cdb_data;

    // Round-robin scan from r_rr_ptr, filling lanes 0..3 with one head per source.
    always_comb begin
        w_grant      = '0;
        w_lane_valid = '0;
        w_lane_idx   = '0;
        w_lane_data  = '0;
        w_rr_next    = r_rr_ptr;
        w_num        = 3'd0;
        w_scan       = '0;
        w_src        = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (RR_W+1)'(k);
            w_scan = (w_scan >= (RR_W+1)'(NUM_SRC)) ? (w_scan - (RR_W+1)'(NUM_SRC)) : w_scan;
            w_src  = w_scan[RR_W-1:0];
            if ((r_count[w_src] != '0) && (w_num < 3'd4)) begin
                w_grant[w_src]            = 1'b1;
                w_lane_valid[w_num[1:0]]  = 1'b1;
                w_lane_idx[w_num[1:0]]    = r_q_idx[w_src][r_rd_ptr[w_src]];
                w_lane_data[w_num[1:0]]   = r_q_data[w_src][r_rd_ptr[w_src]];
                w_rr_next = (w_src == RR_W'(NUM_SRC-1)) ? '0 : (w_src + RR_W'(1));
                w_num     = w_num + 3'd1;
            end else begin
                w_num = w_num;
            end
        end
    end

    // Queue bookkeeping, round-robin pointer and broadcast lane registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_rr_ptr    <= '0;
            r_cdb_valid <= '0;
            r_cdb_idx   <= '0;
            r_cdb_data  <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_cdb_valid <= '0;
            r_cdb_idx   <= '0;
            r_cdb_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                end
                if (w_grant[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                end
                r_count[i] <= r_count[i] + CNT_W'(w_push[i]) - CNT_W'(w_grant[i]);
            end
            r_rr_ptr    <= w_rr_next;
            r_cdb_valid <= w_lane_valid;
            r_cdb_idx   <= w_lane_idx;
            r_cdb_data  <= w_lane_data;
        end
    end

    // Queue storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_push[i] && !flush) begin
                r_q_idx[i][r_wr_ptr[i]]  <= bus.src_rob_index[i];
                r_q_data[i][r_wr_ptr[i]] <= bus.src_result[i];
            end
        end
    end
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: hand-computed vector table, directed
// corner sequences, and random traffic against a queue-based reference model.
module tb_cdb_broadcaster;
    localparam int NUM_SRC = 6;
    localparam int DEPTH   = 2;
    localparam int IDX_W   = 4;
    localparam int DATA_W  = 16;
    localparam int LANES   = 4;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } item_t;

    typedef struct {
        logic                           flush;
        logic [NUM_SRC-1:0]             vld;
        logic [NUM_SRC-1:0][IDX_W-1:0]  idx;
        logic [NUM_SRC-1:0][DATA_W-1:0] dat;
        logic [LANES-1:0]               e_vld;
        logic [LANES-1:0][IDX_W-1:0]    e_idx;
        logic [LANES-1:0][DATA_W-1:0]   e_dat;
        logic [NUM_SRC-1:0]             e_rdy;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;

    cdb_if #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W), .DATA_W(DATA_W)) bus();

    cdb_broadcaster #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    item_t                       mq [NUM_SRC][$];
    int                          m_rr;
    logic [LANES-1:0]            e_vld;
    logic [LANES-1:0][IDX_W-1:0] e_idx;
    logic [LANES-1:0][DATA_W-1:0] e_dat;
    item_t                       pend [NUM_SRC];
    vec_t                        tv[$];
    logic [NUM_SRC-1:0]          acc_s;
    int                          nvec = 0;
    int                          nerr = 0;
    int                          lane0_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model one edge from the current inputs, advance the clock, compare.
    task automatic step(input string tag, output logic [NUM_SRC-1:0] acc);
        int sz [NUM_SRC];
        int n;
        int s;
        int last;
        item_t it;
        logic [NUM_SRC-1:0] e_rdy;
        bit ok;
        acc = '0; e_vld = '0; e_idx = '0; e_dat = '0; n = 0; last = 0;
        for (int i = 0; i < NUM_SRC; i++) sz[i] = mq[i].size();
        if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                s = (m_rr + k) % NUM_SRC;
                if (sz[s] > 0 && n < LANES) begin
                    it = mq[s].pop_front();
                    e_vld[n] = 1'b1;
                    e_idx[n] = it.idx;
                    e_dat[n] = it.data;
                    n++;
                    last = s;
                end
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.src_valid[i] && sz[i] < DEPTH) begin
                    it.idx  = bus.src_rob_index[i];
                    it.data = bus.src_result[i];
                    mq[i].push_back(it);
                    acc[i] = 1'b1;
                end
            end
            if (n > 0) m_rr = (last + 1) % NUM_SRC;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_SRC; i++) e_rdy[i] = (mq[i].size() < DEPTH);
        ok = (bus.cdb_valid === e_vld) && (bus.cdb_rob_index === e_idx) &&
             (bus.cdb_result === e_dat) && (bus.src_ready === e_rdy);
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got vld=%b idx=%h res=%h rdy=%b expected vld=%b idx=%h res=%h rdy=%b",
                     tag, bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result, bus.src_ready,
                     e_vld, e_idx, e_dat, e_rdy);
        end
    endtask

    task automatic new_pend(input int i);
        pend[i].idx  = IDX_W'($urandom);
        pend[i].data = DATA_W'($urandom);
    endtask

    task automatic cyc(input logic f, input logic [NUM_SRC-1:0] mask, input string tag);
        logic [NUM_SRC-1:0] acc;
        flush = f;
        bus.src_valid = mask;
        for (int i = 0; i < NUM_SRC; i++) begin
            bus.src_rob_index[i] = pend[i].idx;
            bus.src_result[i]    = pend[i].data;
        end
        step(tag, acc);
        for (int i = 0; i < NUM_SRC; i++) if (acc[i]) new_pend(i);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        flush = 1'b0;
        bus.src_valid = '0;
        bus.src_rob_index = '0;
        bus.src_result = '0;
        #1;
        chk({tag, "_rst_valid"}, 64'(bus.cdb_valid), 64'd0);
        chk({tag, "_rst_ready"}, 64'(bus.src_ready), 64'h3F);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
        m_rr = 0;
    endtask

    task automatic add(input logic f, input logic [5:0] v, input logic [5:0][3:0] ix,
                       input logic [5:0][15:0] d, input logic [3:0] ev, input logic [3:0][3:0] ei,
                       input logic [3:0][15:0] ed, input logic [5:0] er);
        vec_t t;
        t.flush = f; t.vld = v; t.idx = ix; t.dat = d;
        t.e_vld = ev; t.e_idx = ei; t.e_dat = ed; t.e_rdy = er;
        tv.push_back(t);
    endtask

    initial begin
        bus.src_valid = '0;
        bus.src_rob_index = '0;
        bus.src_result = '0;
        for (int i = 0; i < NUM_SRC; i++) new_pend(i);

        add(1'b0, 6'h3F, {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0},
            {16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001, 16'hA000},
            4'h0, '0, '0, 6'h3F);
        add(1'b0, 6'h00, '0, '0, 4'hF, {4'd3, 4'd2, 4'd1, 4'd0},
            {16'hA003, 16'hA002, 16'hA001, 16'hA000}, 6'h3F);
        add(1'b0, 6'h00, '0, '0, 4'h3, {4'd0, 4'd0, 4'd5, 4'd4},
            {16'h0000, 16'h0000, 16'hA005, 16'hA004}, 6'h3F);
        add(1'b0, 6'h04, {4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0},
            {16'h0, 16'h0, 16'h0, 16'h1234, 16'h0, 16'h0}, 4'h0, '0, '0, 6'h3F);
        add(1'b0, 6'h00, '0, '0, 4'h1, {4'd0, 4'd0, 4'd0, 4'd5},
            {16'h0, 16'h0, 16'h0, 16'h1234}, 6'h3F);
        add(1'b0, 6'h00, '0, '0, 4'h0, '0, '0, 6'h3F);
        add(1'b0, 6'h21, {4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7},
            {16'h5555, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0BEE}, 4'h0, '0, '0, 6'h3F);
        add(1'b0, 6'h00, '0, '0, 4'h3, {4'd0, 4'd0, 4'd7, 4'd9},
            {16'h0, 16'h0, 16'h0BEE, 16'h5555}, 6'h3F);
        add(1'b1, 6'h02, {4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0},
            {16'h0, 16'h0, 16'h0, 16'h0, 16'h7777, 16'h0}, 4'h0, '0, '0, 6'h3F);
        add(1'b0, 6'h00, '0, '0, 4'h0, '0, '0, 6'h3F);
        add(1'b0, 6'h10, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0},
            {16'h0, 16'h1111, 16'h0, 16'h0, 16'h0, 16'h0}, 4'h0, '0, '0, 6'h3F);
        add(1'b0, 6'h10, {4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0},
            {16'h0, 16'h2222, 16'h0, 16'h0, 16'h0, 16'h0}, 4'h1, {4'd0, 4'd0, 4'd0, 4'd1},
            {16'h0, 16'h0, 16'h0, 16'h1111}, 6'h3F);
        add(1'b0, 6'h00, '0, '0, 4'h1, {4'd0, 4'd0, 4'd0, 4'd2},
            {16'h0, 16'h0, 16'h0, 16'h2222}, 6'h3F);
        add(1'b0, 6'h00, '0, '0, 4'h0, '0, '0, 6'h3F);

        #2;
        do_reset("tbl");
        for (int r = 0; r < tv.size(); r++) begin
            flush = tv[r].flush;
            bus.src_valid = tv[r].vld;
            bus.src_rob_index = tv[r].idx;
            bus.src_result = tv[r].dat;
            step($sformatf("tbl%0d_model", r), acc_s);
            nvec++;
            if (bus.cdb_valid !== tv[r].e_vld || bus.cdb_rob_index !== tv[r].e_idx ||
                bus.cdb_result !== tv[r].e_dat || bus.src_ready !== tv[r].e_rdy) begin
                nerr++;
                $display("FAIL tbl%0d: got vld=%b idx=%h res=%h rdy=%b expected vld=%b idx=%h res=%h rdy=%b",
                         r, bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result, bus.src_ready,
                         tv[r].e_vld, tv[r].e_idx, tv[r].e_dat, tv[r].e_rdy);
            end
        end

        // Source 1 stalled behind four others: ready drops, nothing lost, order kept.
        do_reset("A");
        cyc(1'b0, 6'b000010, "A0");
        cyc(1'b0, 6'b000000, "A1");
        cyc(1'b0, 6'b111110, "A2");
        cyc(1'b0, 6'b111110, "A3");
        chk("A_ready1_low", 64'(bus.src_ready[1]), 64'd0);
        for (int c = 0; c < 10; c++) cyc(1'b0, 6'b000010, "A_hold");
        for (int c = 0; c < 4; c++) cyc(1'b0, 6'b000000, "A_drain");

        // Back-to-back stream on source 0 wraps the pointers.
        do_reset("B");
        lane0_seen = 0;
        for (int c = 0; c < 2*DEPTH+1; c++) begin
            cyc(1'b0, 6'b000001, "B_stream");
            if (bus.cdb_valid[0] === 1'b1) lane0_seen++;
        end
        for (int c = 0; c < 3; c++) begin
            cyc(1'b0, 6'b000000, "B_drain");
            if (bus.cdb_valid[0] === 1'b1) lane0_seen++;
        end
        chk("B_count", 64'(lane0_seen), 64'(2*DEPTH+1));

        // Flush with five queued entries and valid held high.
        do_reset("C");
        cyc(1'b0, 6'b011111, "C_fill");
        cyc(1'b1, 6'b111111, "C_flush");
        chk("C_valid", 64'(bus.cdb_valid), 64'd0);
        chk("C_ready", 64'(bus.src_ready), 64'h3F);
        for (int c = 0; c < 3; c++) cyc(1'b0, 6'b000000, "C_after");

        // Asynchronous reset in the middle of a broadcast.
        do_reset("D");
        cyc(1'b0, 6'b001000, "D_push");
        cyc(1'b0, 6'b000000, "D_bcast");
        #2;
        rst_n = 1'b0;
        #1;
        chk("D_async_valid", 64'(bus.cdb_valid), 64'd0);
        chk("D_async_idx", 64'(bus.cdb_rob_index), 64'd0);
        chk("D_async_ready", 64'(bus.src_ready), 64'h3F);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
        m_rr = 0;
        pend[2].idx = 4'd5;
        pend[2].data = 16'h1234;
        cyc(1'b0, 6'b000100, "D_new");
        cyc(1'b0, 6'b000000, "D_out");
        chk("D_lane0", {44'd0, bus.cdb_valid, bus.cdb_rob_index[0], bus.cdb_result[0]},
            {44'd0, 4'h1, 4'd5, 16'h1234});

        // Random traffic with occasional flushes.
        for (int c = 0; c < 400; c++) begin
            logic [NUM_SRC-1:0] m;
            for (int i = 0; i < NUM_SRC; i++) m[i] = ($urandom_range(0, 99) < 65);
            cyc(($urandom_range(0, 99) < 3), m, "rand");
        end
        for (int c = 0; c < 4; c++) cyc(1'b0, 6'b000000, "rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
